stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Multi-cycle control unit for the 8-bit stack processor. Sequences instruction fetch, decode, operand pops, ALU execution and result pushes against the 32-entry stack, the unified 32-byte memory and the PC/IR/A/B datapath registers. Also tracks stack occupancy and halts with a fault code on underflow or overflow. Sits between the IR opcode field and every datapath strobe.

## Interface
- `DEPTH`, default 32: stack entries. Occupancy counter width is clog2(DEPTH)+1.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: leaves IDLE; sampled only in IDLE.
- `opcode` in 3: IR[7:5]. ADD=000, SUB=001, AND=010, NOT=011, PUSH=100, POP=101, JMP=110, JZ=111.
- `zero` in 1: datapath flag, (stack d_out == 0).
- `adr_sel` out 1: memory address source. 0=PC, 1=IR[4:0].
- `mem_we` out 1: memory write; write data is the stack d_out.
- `ir_ld` out 1: load IR from memory read data.
- `pc_ld` out 1: load PC.
- `pc_sel` out 1: PC source. 0=PC+1, 1=IR[4:0].
- `stk_push`, `stk_pop`, `stk_tos` out 1 each: stack strobes; at most one high per cycle.
- `din_sel` out 1: stack push data source. 0=memory read data, 1=ALU result.
- `a_ld`, `b_ld` out 1 each: capture stack d_out into A or B.
- `alu_op` out 2: 00=A+B, 01=A−B, 10=A&B, 11=~A.
- `halted` out 1: in HALT state.
- `fault` out 2: 00 none, 01 underflow, 10 overflow.

## Operation
- Moore FSM; all strobes decode from the state register. Only `pc_ld` in TEST also depends on `zero`.
- States: IDLE, IF, LD_IR, DEC, POP_B, LD_B, LD_A, POP_A, EXEC, MEM_RD, PUSH_M, POP_S, STORE, TOS, TEST, HALT.
- IF: `adr_sel`=0. Next state: LD_IR.
- LD_IR: `ir_ld`=1, `pc_ld`=1, `pc_sel`=0. Next state: DEC.
- DEC: no strobes, except JMP asserts `pc_ld`=1 and `pc_sel`=1. Runs the occupancy check, then dispatches by opcode:
  - ADD/SUB/AND → POP_B
  - NOT → POP_A
  - PUSH → MEM_RD
  - POP → POP_S
  - JMP → IF
  - JZ → TOS
- Binary ops: POP_B (`stk_pop`) → LD_B (`b_ld`, `stk_pop`) → LD_A (`a_ld`) → EXEC (`stk_push`, `din_sel`=1, `alu_op`=opcode[1:0]) → IF.
  - First pop (top of stack) goes to B, second to A. SUB pushes second − top.
- NOT: POP_A (`stk_pop`) → LD_A (`a_ld`) → EXEC → IF.
- PUSH: MEM_RD (`adr_sel`=1) → PUSH_M (`stk_push`, `din_sel`=0) → IF.
- POP: POP_S (`stk_pop`) → STORE (`adr_sel`=1, `mem_we`) → IF.
- JZ: TOS (`stk_tos`) → TEST (`pc_sel`=1, `pc_ld`=`zero`) → IF. JZ does not pop.
- Occupancy counter:
  - +1 on `stk_push`, −1 on `stk_pop`, unchanged on `stk_tos`.
  - 8-bit data wraps modulo 256 in the ALU; the controller does no arithmetic on data.
- Occupancy check in DEC:
  - ADD/SUB/AND need count ≥ 2.
  - NOT, POP and JZ need count ≥ 1.
  - PUSH needs count ≤ DEPTH−1.
  - On failure: go to HALT with no strobe issued, `fault` set (01 underflow, 10 overflow).
- HALT: all strobes 0, `halted`=1. Left only by reset.
- Reset at any point, mid-instruction included:
  - state = IDLE, count = 0, `fault` = 00.
  - A partially executed instruction is abandoned. Stack contents are not cleared; the counter restarts at 0.

## Timing
- Reset value of every output is 0, including `fault` = 00 and `halted` = 0.
- `start` high in IDLE → IF on the next edge.
- Stack d_out is registered: a pop or tos in cycle t makes data valid in cycle t+1. Hence `b_ld`/`a_ld` follow their pop by exactly one state.
- Memory read is synchronous: address presented in cycle t, data valid in cycle t+1.
- Cycles per instruction, IF through the last state:
  - ADD/SUB/AND: 7
  - NOT: 6
  - PUSH: 5
  - POP: 5
  - JZ: 5
  - JMP: 3
- `pc_ld` in LD_IR and in DEC/TEST land on separate cycles, so the jump target always overrides the increment.

## Structure
- `stack_pkg` holds:
  - opcode constants
  - state enum
  - `alu_op` encodings
  - `fault` encodings
  - DEPTH default
- Sub-module `stack_depth_cnt`: occupancy counter plus `can_pop1`, `can_pop2` and `can_push` flags, driven by the push/pop strobes.
- The FSM sits in `stack_ctrl`.

## Test plan
- Reset, then `start`; program PUSH 10 (mem[10]=5), PUSH 11 (mem[11]=3), SUB, POP 12 → mem[12]=2, count back to 0, each instruction takes its listed cycle count.
- ADD with operands 200 and 100 → 44 pushed (wrap modulo 256), `alu_op`=00 seen in EXEC.
- JZ with top=0 → PC loaded with IR[4:0]. JZ with top=7 → PC+1 kept, count unchanged.
- ADD with count=1 → HALT, `fault`=01, no `stk_pop` ever asserted; `halted` stays 1 until `rst_n`=0.
- 33rd PUSH with count=32 → HALT, `fault`=10, `stk_push` never asserted.
- `rst_n` low during LD_B of ADD → next cycle IDLE, all outputs 0, count=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the 8-bit stack processor control path.
// Opcodes, controller states, ALU selects and fault codes.
package stack_pkg;

    localparam int DEPTH_DEF = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_UNDER = 2'b01;
    localparam logic [1:0] FLT_OVER  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_IF,
        S_LD_IR,
        S_DEC,
        S_POP_B,
        S_LD_B,
        S_LD_A,
        S_POP_A,
        S_EXEC,
        S_MEM_RD,
        S_PUSH_M,
        S_POP_S,
        S_STORE,
        S_TOS,
        S_TEST,
        S_HALT
    } state_t;

endpackage

// File: rtl/stack_depth_cnt.sv
// Stack occupancy counter for the stack processor controller.
// Tracks push/pop strobes and flags whether pops or a push are safe.
module stack_depth_cnt
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    output logic can_pop1,
    output logic can_pop2,
    output logic can_push
);

    logic [CW-1:0] count;

    // occupancy follows the strobes; tos leaves it alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    assign can_pop1 = (count >= CW'(1));
    assign can_pop2 = (count >= CW'(2));
    assign can_push = (count <= CW'(DEPTH - 1));

endmodule

// File: rtl/stack_ctrl.sv
// Multi-cycle control FSM for the 8-bit stack processor.
// Drives every datapath strobe from the state register.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       adr_sel,
    output logic       mem_we,
    output logic       ir_ld,
    output logic       pc_ld,
    output logic       pc_sel,
    output logic       stk_push,
    output logic       stk_pop,
    output logic       stk_tos,
    output logic       din_sel,
    output logic       a_ld,
    output logic       b_ld,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic [1:0] fault
);

    state_t     state;
    state_t     dec_next;
    logic [1:0] dec_fault;
    logic       can_pop1;
    logic       can_pop2;
    logic       can_push;

    stack_depth_cnt #(
        .DEPTH (DEPTH)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (stk_push),
        .pop      (stk_pop),
        .can_pop1 (can_pop1),
        .can_pop2 (can_pop2),
        .can_push (can_push)
    );

    // dispatch by opcode, diverting to HALT when occupancy forbids it
    always_comb begin
        dec_next  = S_IF;
        dec_fault = FLT_NONE;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND: begin
                dec_next = S_POP_B;
                if (!can_pop2) begin
                    dec_next  = S_HALT;
                    dec_fault = FLT_UNDER;
                end
            end
            OP_NOT: begin
                dec_next = S_POP_A;
                if (!can_pop1) begin
                    dec_next  = S_HALT;
                    dec_fault = FLT_UNDER;
                end
            end
            OP_PUSH: begin
                dec_next = S_MEM_RD;
                if (!can_push) begin
                    dec_next  = S_HALT;
                    dec_fault = FLT_OVER;
                end
            end
            OP_POP: begin
                dec_next = S_POP_S;
                if (!can_pop1) begin
                    dec_next  = S_HALT;
                    dec_fault = FLT_UNDER;
                end
            end
            OP_JMP: dec_next = S_IF;
            OP_JZ: begin
                dec_next = S_TOS;
                if (!can_pop1) begin
                    dec_next  = S_HALT;
                    dec_fault = FLT_UNDER;
                end
            end
            default: dec_next = S_IF;
        endcase
    end

    // state sequencing plus the sticky halt/fault registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            fault  <= FLT_NONE;
            halted <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE:   if (start) state <= S_IF;
                S_IF:     state <= S_LD_IR;
                S_LD_IR:  state <= S_DEC;
                S_DEC: begin
                    state <= dec_next;
                    fault <= dec_fault;
                    if (dec_next == S_HALT) halted <= 1'b1;
                end
                S_POP_B:  state <= S_LD_B;
                S_LD_B:   state <= S_LD_A;
                S_POP_A:  state <= S_LD_A;
                S_LD_A:   state <= S_EXEC;
                S_EXEC:   state <= S_IF;
                S_MEM_RD: state <= S_PUSH_M;
                S_PUSH_M: state <= S_IF;
                S_POP_S:  state <= S_STORE;
                S_STORE:  state <= S_IF;
                S_TOS:    state <= S_TEST;
                S_TEST:   state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // strobe decode; only the JZ test looks at the zero flag
    always_comb begin
        adr_sel  = 1'b0;
        mem_we   = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        pc_sel   = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_tos  = 1'b0;
        din_sel  = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        alu_op   = ALU_ADD;
        unique case (state)
            S_LD_IR: begin
                ir_ld = 1'b1;
                pc_ld = 1'b1;
            end
            S_DEC: begin
                if (opcode == OP_JMP) begin
                    pc_ld  = 1'b1;
                    pc_sel = 1'b1;
                end
            end
            S_POP_B:  stk_pop = 1'b1;
            S_LD_B: begin
                b_ld    = 1'b1;
                stk_pop = 1'b1;
            end
            S_POP_A:  stk_pop = 1'b1;
            S_LD_A:   a_ld = 1'b1;
            S_EXEC: begin
                stk_push = 1'b1;
                din_sel  = 1'b1;
                alu_op   = opcode[1:0];
            end
            S_MEM_RD: adr_sel = 1'b1;
            S_PUSH_M: stk_push = 1'b1;
            S_POP_S:  stk_pop = 1'b1;
            S_STORE: begin
                adr_sel = 1'b1;
                mem_we  = 1'b1;
            end
            S_TOS:    stk_tos = 1'b1;
            S_TEST: begin
                pc_sel = 1'b1;
                pc_ld  = zero;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural datapath around the controller.
// Expected fetches, CPIs, ALU pushes and stores are queued and popped.
module tb_stack_ctrl;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode;
    logic       zero;
    logic       adr_sel, mem_we, ir_ld, pc_ld, pc_sel;
    logic       stk_push, stk_pop, stk_tos, din_sel, a_ld, b_ld;
    logic [1:0] alu_op;
    logic       halted;
    logic [1:0] fault;

    always #5 clk = ~clk;

    stack_ctrl #(.DEPTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .opcode   (opcode),
        .zero     (zero),
        .adr_sel  (adr_sel),
        .mem_we   (mem_we),
        .ir_ld    (ir_ld),
        .pc_ld    (pc_ld),
        .pc_sel   (pc_sel),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .din_sel  (din_sel),
        .a_ld     (a_ld),
        .b_ld     (b_ld),
        .alu_op   (alu_op),
        .halted   (halted),
        .fault    (fault)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [15:0] outs;
    assign outs = {adr_sel, mem_we, ir_ld, pc_ld, pc_sel, stk_push,
                   stk_pop, stk_tos, din_sel, a_ld, b_ld, alu_op,
                   halted, fault};

    // behavioural datapath
    logic [7:0] prog [32];
    logic [7:0] mem  [32];
    logic [7:0] stk  [32];
    logic [5:0] sp;
    logic [4:0] top;
    logic [4:0] pc;
    logic [7:0] d_out, rdata, ir, a, b, alu_res, din;

    assign top    = sp[4:0] - 5'd1;
    assign opcode = ir[7:5];
    assign zero   = (d_out == 8'd0);

    always_comb begin
        case (alu_op)
            2'b00:   alu_res = a + b;
            2'b01:   alu_res = a - b;
            2'b10:   alu_res = a & b;
            default: alu_res = ~a;
        endcase
        din = din_sel ? alu_res : rdata;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            mem   <= prog;
            sp    <= '0;
            pc    <= '0;
            d_out <= '0;
            rdata <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
        end else begin
            rdata <= mem[adr_sel ? ir[4:0] : pc];
            if (mem_we) mem[ir[4:0]] <= d_out;
            if (ir_ld) ir <= rdata;
            if (pc_ld) pc <= pc_sel ? ir[4:0] : pc + 5'd1;
            if (a_ld) a <= d_out;
            if (b_ld) b <= d_out;
            if (stk_push) begin
                stk[sp[4:0]] <= din;
                sp <= sp + 6'd1;
            end else if (stk_pop) begin
                d_out <= stk[top];
                sp <= sp - 6'd1;
            end else if (stk_tos) begin
                d_out <= stk[top];
            end
        end
    end

    // scoreboard queues
    int addr_q[$];
    int cpi_q[$];
    int wr_q[$];
    int alu_q[$];
    int cyc = 0;
    int prev_cyc = 0;
    bit have_prev = 0;
    int n_push = 0;
    int n_pop = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stk_push) n_push++;
            if (stk_pop) n_pop++;
            if (ir_ld && addr_q.size() != 0) begin
                check("fetch_addr", 32'(pc), addr_q.pop_front());
                if (have_prev && cpi_q.size() != 0)
                    check("cpi", cyc - prev_cyc, cpi_q.pop_front());
                have_prev = 1;
                prev_cyc  = cyc;
            end
            if (stk_push && din_sel) begin
                if (alu_q.size() == 0)
                    check("alu_unexp", 1, 0);
                else
                    check("alu_push", {22'd0, alu_op, din},
                          alu_q.pop_front());
            end
            if (mem_we) begin
                if (wr_q.size() == 0)
                    check("wr_unexp", 1, 0);
                else
                    check("mem_wr", {19'd0, ir[4:0], d_out},
                          wr_q.pop_front());
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
        addr_q.delete();
        cpi_q.delete();
        wr_q.delete();
        alu_q.delete();
    endtask

    task automatic boot();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        have_prev = 0;
        n_push = 0;
        n_pop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (addr_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, addr_q.size(), 0);
        check("cpi_left", cpi_q.size(), 0);
        check("alu_left", alu_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
    endtask

    task automatic wait_halt(input string tag);
        int k = 0;
        while (!halted && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, halted, 1);
    endtask

    task automatic fill(input int q[$], input int kind);
        foreach (q[i]) begin
            if (kind == 0) addr_q.push_back(q[i]);
            else cpi_q.push_back(q[i]);
        end
    endtask

    initial begin
        clear_all();
        repeat (3) @(negedge clk);
        check("rst_outs", 32'(outs), 0);
        check("rst_count", 32'(dut.u_cnt.count), 0);

        // PUSH 10, PUSH 11, SUB, POP 12, JMP 4
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'h8B; prog[2] = 8'h20;
        prog[3] = 8'hAC; prog[4] = 8'hC4;
        prog[10] = 8'd5; prog[11] = 8'd3;
        fill('{0, 1, 2, 3, 4, 4}, 0);
        fill('{5, 5, 7, 5, 3}, 1);
        alu_q.push_back((1 << 8) + 2);
        wr_q.push_back((12 << 8) + 2);
        boot();
        wait_drain("p1_drain");
        check("p1_count", 32'(dut.u_cnt.count), 0);
        check("p1_fault", 32'(fault), 0);

        // PUSH 200, PUSH 100, ADD, NOT, POP 12, JMP 5
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'h8B; prog[2] = 8'h00;
        prog[3] = 8'h60; prog[4] = 8'hAC; prog[5] = 8'hC5;
        prog[10] = 8'd200; prog[11] = 8'd100;
        fill('{0, 1, 2, 3, 4, 5, 5}, 0);
        fill('{5, 5, 7, 6, 5, 3}, 1);
        alu_q.push_back(44);
        alu_q.push_back((3 << 8) + 211);
        wr_q.push_back((12 << 8) + 211);
        boot();
        wait_drain("p2_drain");
        check("p2_count", 32'(dut.u_cnt.count), 0);

        // JZ taken: top = 0
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'hE8; prog[8] = 8'hC8;
        prog[10] = 8'd0;
        fill('{0, 1, 8, 8}, 0);
        fill('{5, 5, 3}, 1);
        boot();
        wait_drain("p3_drain");
        check("p3_count", 32'(dut.u_cnt.count), 1);

        // JZ not taken: top = 7
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'hE8; prog[2] = 8'hC2;
        prog[10] = 8'd7;
        fill('{0, 1, 2, 2}, 0);
        fill('{5, 5, 3}, 1);
        boot();
        wait_drain("p4_drain");
        check("p4_count", 32'(dut.u_cnt.count), 1);

        // ADD with one entry: underflow
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'h00; prog[10] = 8'd9;
        fill('{0, 1}, 0);
        fill('{5}, 1);
        boot();
        wait_halt("p5_halt");
        check("p5_fault", 32'(fault), 1);
        check("p5_drain", addr_q.size() + cpi_q.size(), 0);
        @(negedge clk);
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        check("p5_hold", {halted, fault}, 3'b101);
        check("p5_outs", 32'(outs[15:3]), 0);
        check("p5_no_pop", n_pop, 0);
        check("p5_count", 32'(dut.u_cnt.count), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("p5_rst", 32'(outs), 0);
        rst_n = 1'b1;

        // 33rd PUSH: overflow
        clear_all();
        prog[0] = 8'h9F; prog[1] = 8'hC0; prog[31] = 8'h55;
        for (int i = 0; i < 32; i++) begin
            addr_q.push_back(0);
            addr_q.push_back(1);
            cpi_q.push_back(5);
            cpi_q.push_back(3);
        end
        addr_q.push_back(0);
        boot();
        wait_halt("p6_halt");
        check("p6_fault", 32'(fault), 2);
        check("p6_drain", addr_q.size() + cpi_q.size(), 0);
        check("p6_pushes", n_push, 32);
        check("p6_count", 32'(dut.u_cnt.count), 32);

        // reset during LD_B of ADD
        clear_all();
        prog[0] = 8'h8A; prog[1] = 8'h8B; prog[2] = 8'h00;
        prog[10] = 8'd1; prog[11] = 8'd2;
        boot();
        begin
            int k = 0;
            while (!b_ld && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        check("p7_ld_b", b_ld, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("p7_outs", 32'(outs), 0);
        check("p7_count", 32'(dut.u_cnt.count), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("p7_idle", 32'(outs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
